// File: rtl/fetch_queue.sv
// fetch_queue: circular-buffer instruction fetch queue between the i-cache
// output and the i2d pipeline register. Each entry holds a PC and an
// instruction word; the head entry is presented on out_* and leaves the queue
// on a valid/ready handshake.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an instruction arriving
// at an empty queue appear on out_* in the same cycle. If the consumer takes
// it in that cycle, it is never written into storage. The default build (macro
// undefined) has no combinational path from push_* to out_*.
module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push_valid,
  input  logic [DATA_WIDTH-1:0]        push_pc,
  input  logic [DATA_WIDTH-1:0]        push_inst,
  output logic                         push_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_pc,
  output logic [DATA_WIDTH-1:0]        out_inst,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] r_pcMem   [DEPTH];
  logic [DATA_WIDTH-1:0] r_instMem [DEPTH];
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W-1:0]      r_wrPtr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_notEmpty;
  logic                  w_bypass;
  logic                  w_pushFire;
  logic                  w_popFire;
  logic [PTR_W-1:0]      w_rdPtrNext;
  logic [PTR_W-1:0]      w_wrPtrNext;
  logic [CNT_W-1:0]      w_countNext;
  logic                  w_outValid;
  logic [DATA_WIDTH-1:0] w_outPc;
  logic [DATA_WIDTH-1:0] w_outInst;

  // Handshake decode: which transfers actually happen this cycle; flush kills both.
  always_comb begin
    w_notEmpty = (r_count != '0);
    push_ready = (r_count != FULL_CNT);
`ifdef FETCH_QUEUE_BYPASS_EN
    w_bypass   = ~rst & ~w_notEmpty & push_valid & ~flush;
`else
    w_bypass   = 1'b0;
`endif
    w_popFire  = w_notEmpty & out_ready & ~flush;
    w_pushFire = push_valid & push_ready & ~flush & ~(w_bypass & out_ready);
  end

  // Next pointer and count values; pointers wrap explicitly from the last slot to 0.
  always_comb begin
    w_rdPtrNext = r_rdPtr;
    w_wrPtrNext = r_wrPtr;
    w_countNext = r_count;
    if (w_popFire) begin
      w_rdPtrNext = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + 1'b1;
    end
    if (w_pushFire) begin
      w_wrPtrNext = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + 1'b1;
    end
    case ({w_pushFire, w_popFire})
      2'b10:   w_countNext = r_count + 1'b1;
      2'b01:   w_countNext = r_count - 1'b1;
      default: w_countNext = r_count;
    endcase
    if (flush) begin
      w_rdPtrNext = '0;
      w_wrPtrNext = '0;
      w_countNext = '0;
    end
  end

  // Pointer and count state; flush is folded into the next-state values above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      r_rdPtr <= w_rdPtrNext;
      r_wrPtr <= w_wrPtrNext;
      r_count <= w_countNext;
    end
  end

  // Entry storage: written at the tail on an accepted push, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pcMem[i]   <= '0;
        r_instMem[i] <= '0;
      end
    end else if (w_pushFire) begin
      r_pcMem[r_wrPtr]   <= push_pc;
      r_instMem[r_wrPtr] <= push_inst;
    end
  end

  // Head presentation: the bypassed word when active, else the stored head, else zeros.
  always_comb begin
    w_outValid = w_notEmpty | w_bypass;
    w_outPc    = '0;
    w_outInst  = '0;
    if (w_bypass) begin
      w_outPc   = push_pc;
      w_outInst = push_inst;
    end else if (w_notEmpty) begin
      w_outPc   = r_pcMem[r_rdPtr];
      w_outInst = r_instMem[r_rdPtr];
    end
    out_valid = w_outValid;
    out_pc    = w_outPc;
    out_inst  = w_outInst;
    occupancy = r_count;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic for fetch_queue,
// checked against a queue-based reference model of the FIFO behaviour.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          push_valid;
  logic [DW-1:0] push_pc;
  logic [DW-1:0] push_inst;
  logic          push_ready;
  logic          out_valid;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] out_inst;
  logic          out_ready;
  logic [2:0]    occupancy;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model: each element is {pc, inst}, front is the queue head.
  logic [2*DW-1:0] modelQ[$];

  fetch_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_pc    (push_pc),
    .push_inst  (push_inst),
    .push_ready (push_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_ready  (out_ready),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every output against given expected values.
  task automatic checkAll(input string tag, input logic expReady, input logic expValid,
                          input logic [DW-1:0] expPc, input logic [DW-1:0] expInst, input int expOcc);
    checkOutput({tag, ".push_ready"}, 64'(push_ready), 64'(expReady));
    checkOutput({tag, ".out_valid"},  64'(out_valid),  64'(expValid));
    checkOutput({tag, ".out_pc"},     64'(out_pc),     64'(expPc));
    checkOutput({tag, ".out_inst"},   64'(out_inst),   64'(expInst));
    checkOutput({tag, ".occupancy"},  64'(occupancy),  64'(expOcc));
  endtask

  // One clock cycle: drive at the falling edge, check mid-low phase, advance model at the rising edge.
  task automatic applyStimulus(input string tag, input logic f, input logic pv,
                               input logic [DW-1:0] pc, input logic [DW-1:0] inst, input logic ordy);
    int size;
    logic expReady, expValid, bypass;
    logic [DW-1:0] expPc, expInst;
    flush      = f;
    push_valid = pv;
    push_pc    = pc;
    push_inst  = inst;
    out_ready  = ordy;
    #1;
    size     = modelQ.size();
    expReady = (size != DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass   = (size == 0) && pv && !f;
`else
    bypass   = 1'b0;
`endif
    expValid = (size != 0) || bypass;
    expPc    = '0;
    expInst  = '0;
    if (bypass) begin
      expPc   = pc;
      expInst = inst;
    end else if (size != 0) begin
      expPc   = modelQ[0][2*DW-1:DW];
      expInst = modelQ[0][DW-1:0];
    end
    checkAll(tag, expReady, expValid, expPc, expInst, size);
    @(posedge clk);
    if (f) begin
      modelQ.delete();
    end else if (!(bypass && ordy)) begin
      if (size != 0 && ordy) void'(modelQ.pop_front());
      if (pv && expReady) modelQ.push_back({pc, inst});
    end
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    push_valid = 1'b0;
    push_pc    = '0;
    push_inst  = '0;
    out_ready  = 1'b0;

    // Reset state while rst is held.
    @(negedge clk);
    #1;
    checkAll("reset", 1'b1, 1'b0, '0, '0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fill: five pushes with consumer stalled; the fifth must be refused.
    for (int i = 0; i < 5; i++)
      applyStimulus("fill", 1'b0, 1'b1, DW'(i * 4), DW'(32'hA000_0000 + i), 1'b0);
    checkOutput("fill.modelSize", 64'(modelQ.size()), 64'(DEPTH));

    // Drain in order, then confirm empty outputs are zero.
    for (int i = 0; i < 4; i++)
      applyStimulus("drain", 1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus("drainEmpty", 1'b0, 1'b0, '0, '0, 1'b1);

    // Steady state at occupancy 2 with simultaneous push and pop across wrap.
    applyStimulus("pre2", 1'b0, 1'b1, 32'h100, 32'hB000_0000, 1'b0);
    applyStimulus("pre2", 1'b0, 1'b1, 32'h104, 32'hB000_0001, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus("pushPop", 1'b0, 1'b1, DW'(32'h108 + i * 4), DW'(32'hB000_0002 + i), 1'b1);
    applyStimulus("pushPopOcc", 1'b0, 1'b0, '0, '0, 1'b0);

    // Flush at occupancy 3 alongside a push: everything discarded.
    applyStimulus("preFlush", 1'b0, 1'b1, 32'h200, 32'hC000_0000, 1'b0);
    applyStimulus("flush", 1'b1, 1'b1, 32'h204, 32'hC000_0001, 1'b1);
    applyStimulus("postFlush", 1'b0, 1'b0, '0, '0, 1'b0);

    // Mid-stream reset at occupancy 2: outputs clear immediately, push works after release.
    applyStimulus("preRst", 1'b0, 1'b1, 32'h300, 32'hD000_0000, 1'b0);
    applyStimulus("preRst", 1'b0, 1'b1, 32'h304, 32'hD000_0001, 1'b0);
    push_valid = 1'b0;
    rst        = 1'b1;
    #1;
    modelQ.delete();
    checkAll("midRst", 1'b1, 1'b0, '0, '0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("rstPush", 1'b0, 1'b1, 32'h400, 32'hE000_0000, 1'b0);
    applyStimulus("rstVisible", 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("rstVisible.modelSize", 64'(modelQ.size()), 64'd1);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Bypass at an empty queue: same-cycle visibility and nothing stored.
    applyStimulus("bypEmpty", 1'b1, 1'b0, '0, '0, 1'b0);
    applyStimulus("bypass", 1'b0, 1'b1, 32'h40, 32'hF000_0000, 1'b1);
    applyStimulus("bypassAfter", 1'b0, 1'b0, '0, '0, 1'b0);
`endif

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      applyStimulus("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                    DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
